// File: rtl/bsg_dispatch_pkg.sv
// Shared types and helpers for the round-robin dispatcher: pointer sizing,
// wrap-around increment and the ordering-mode enumeration.
package bsg_dispatch_pkg;

  typedef enum logic {
    ModeSkip   = 1'b0,
    ModeStrict = 1'b1
  } dispatch_mode_e;

  // Pointer/tag width: max(1, clog2(els)).
  function automatic int unsigned ptr_width(input int unsigned els);
    int unsigned w;
    w = $clog2(els);
    return (w < 1) ? 1 : w;
  endfunction

  // Explicit compare so non-power-of-two slot counts wrap correctly.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned els);
    return (idx == els - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bsg_round_robin_dispatch_if.sv
// Producer/consumer-side signal bundle of the round-robin dispatcher.
// slave is the dispatcher's view; master is the view of the surrounding logic.
interface bsg_round_robin_dispatch_if
  import bsg_dispatch_pkg::*;
#(
  parameter int unsigned els_p   = 2,
  parameter int unsigned width_p = 32
);

  localparam int unsigned tag_w_lp = ptr_width(els_p);

  logic                       v_i;
  logic [width_p-1:0]         data_i;
  logic                       ready_o;
  logic [els_p-1:0]           v_o;
  logic [els_p*width_p-1:0]   data_o;
  logic [tag_w_lp-1:0]        tag_o;
  logic [els_p-1:0]           yumi_i;

  modport slave (
    input  v_i,
    input  data_i,
    input  yumi_i,
    output ready_o,
    output v_o,
    output data_o,
    output tag_o
  );

  modport master (
    output v_i,
    output data_i,
    output yumi_i,
    input  ready_o,
    input  v_o,
    input  data_o,
    input  tag_o
  );

endinterface

// File: rtl/bsg_rr_dispatch_scan.sv
// Rotating find-first-set: first set bit of avail_i scanning from ptr_i upward
// with wrap; idx_o falls back to ptr_i when nothing is set.
module bsg_rr_dispatch_scan #(
  parameter int unsigned els_p   = 2,
  parameter int unsigned ptr_w_p = 1
) (
  input  logic [els_p-1:0]   avail_i,
  input  logic [ptr_w_p-1:0] ptr_i,
  output logic [ptr_w_p-1:0] idx_o,
  output logic               found_o
);

  int unsigned        k;
  logic [ptr_w_p-1:0] k_idx;
  logic               hit;

  always_comb begin
    idx_o = ptr_i;
    hit   = 1'b0;
    k     = 0;
    k_idx = '0;
    for (int unsigned i = 0; i < els_p; i++) begin
      k = 32'(ptr_i) + i;
      if (k >= els_p) begin
        k = k - els_p;
      end
      k_idx = k[ptr_w_p-1:0];
      if (!hit && avail_i[k_idx]) begin
        idx_o = k_idx;
        hit   = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/bsg_round_robin_dispatch.sv
// Single-producer, multi-consumer dispatcher: deals each accepted word to one of
// els_p registered output slots in rotating order (strict or skip-occupied).
module bsg_round_robin_dispatch
  import bsg_dispatch_pkg::*;
#(
  parameter int unsigned els_p    = 2,
  parameter int unsigned width_p  = 32,
  parameter int unsigned strict_p = 0
) (
  input logic                        clk_i,
  input logic                        reset_n_i,
  bsg_round_robin_dispatch_if.slave  io
);

  localparam int unsigned    ptr_w_lp = ptr_width(els_p);
  localparam dispatch_mode_e mode_lp  = (strict_p != 0) ? ModeStrict : ModeSkip;

  logic [ptr_w_lp-1:0]             ptr_q, ptr_d, tag;
  logic [els_p-1:0]                v_q, v_d, avail;
  logic [els_p-1:0][width_p-1:0]   data_q;
  logic                            ready, accept;

  // A slot being drained this cycle may be refilled on the same edge.
  assign avail = ~v_q | io.yumi_i;

  if (mode_lp == ModeStrict) begin : g_strict
    assign tag   = ptr_q;
    assign ready = avail[ptr_q];
  end else begin : g_skip
    bsg_rr_dispatch_scan #(
      .els_p   (els_p),
      .ptr_w_p (ptr_w_lp)
    ) u_scan (
      .avail_i (avail),
      .ptr_i   (ptr_q),
      .idx_o   (tag),
      .found_o (ready)
    );
  end

  assign accept = io.v_i & ready;

  always_comb begin
    v_d   = v_q & ~io.yumi_i;
    ptr_d = ptr_q;
    if (accept) begin
      v_d[tag] = 1'b1;
      ptr_d    = ptr_w_lp'(wrap_inc(32'(tag), els_p));
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q   <= '0;
      ptr_q <= '0;
    end else begin
      v_q   <= v_d;
      ptr_q <= ptr_d;
    end
  end

  // Payload needs no reset: it is only observed through v_q.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      data_q[tag] <= io.data_i;
    end
  end

  assign io.ready_o = ready;
  assign io.tag_o   = tag;
  assign io.v_o     = v_q;
  assign io.data_o  = data_q;

  yumi_only_when_valid_a : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) ((io.yumi_i & ~v_q) == '0)
  );

endmodule

// File: tb/tb_bsg_round_robin_dispatch.sv
// Directed table-driven bench for three dispatcher configurations:
// els_p=2 skip, els_p=3 skip, els_p=3 strict.
module tb_bsg_round_robin_dispatch;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bsg_round_robin_dispatch_if #(.els_p(2), .width_p(8)) if0 ();
  bsg_round_robin_dispatch_if #(.els_p(3), .width_p(8)) if1 ();
  bsg_round_robin_dispatch_if #(.els_p(3), .width_p(8)) if2 ();

  bsg_round_robin_dispatch #(.els_p(2), .width_p(8), .strict_p(0)) u_d2 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (if0)
  );

  bsg_round_robin_dispatch #(.els_p(3), .width_p(8), .strict_p(0)) u_s3 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (if1)
  );

  bsg_round_robin_dispatch #(.els_p(3), .width_p(8), .strict_p(1)) u_t3 (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .io        (if2)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic       v;
    logic [7:0] data;
    logic [2:0] yumi;
    logic       rdy;
    logic [1:0] tag;
    logic [2:0] vo;
    logic [1:0] slot;
    logic       chk;
    logic [7:0] sdata;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input int sel, input int v, input int data, input int yumi,
                              input int rdy, input int tag, input int vo,
                              input int chk, input int slot, input int sdata);
    vec_t r;
    r.sel   = 2'(sel);
    r.v     = 1'(v);
    r.data  = 8'(data);
    r.yumi  = 3'(yumi);
    r.rdy   = 1'(rdy);
    r.tag   = 2'(tag);
    r.vo    = 3'(vo);
    r.chk   = 1'(chk);
    r.slot  = 2'(slot);
    r.sdata = 8'(sdata);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    if0.v_i = 1'b0; if0.data_i = '0; if0.yumi_i = '0;
    if1.v_i = 1'b0; if1.data_i = '0; if1.yumi_i = '0;
    if2.v_i = 1'b0; if2.data_i = '0; if2.yumi_i = '0;
  endtask

  task automatic get_out(input int sel, output logic [31:0] rdy, output logic [31:0] tag,
                         output logic [31:0] vo);
    case (sel)
      0: begin rdy = 32'(if0.ready_o); tag = 32'(if0.tag_o); vo = 32'(if0.v_o); end
      1: begin rdy = 32'(if1.ready_o); tag = 32'(if1.tag_o); vo = 32'(if1.v_o); end
      default: begin rdy = 32'(if2.ready_o); tag = 32'(if2.tag_o); vo = 32'(if2.v_o); end
    endcase
  endtask

  task automatic get_slot(input int sel, input int slot, output logic [31:0] d);
    case (sel)
      0: d = 32'(if0.data_o[slot*8 +: 8]);
      1: d = 32'(if1.data_o[slot*8 +: 8]);
      default: d = 32'(if2.data_o[slot*8 +: 8]);
    endcase
  endtask

  task automatic apply(input int idx, input vec_t t);
    logic [31:0] rdy, tag, vo, d;
    @(negedge clk);
    idle_all();
    case (t.sel)
      2'd0: begin if0.v_i = t.v; if0.data_i = t.data; if0.yumi_i = t.yumi[1:0]; end
      2'd1: begin if1.v_i = t.v; if1.data_i = t.data; if1.yumi_i = t.yumi; end
      default: begin if2.v_i = t.v; if2.data_i = t.data; if2.yumi_i = t.yumi; end
    endcase
    #1;
    get_out(int'(t.sel), rdy, tag, vo);
    check($sformatf("v%0d_ready", idx), rdy, 32'(t.rdy));
    check($sformatf("v%0d_tag", idx), tag, 32'(t.tag));
    @(posedge clk);
    #1;
    get_out(int'(t.sel), rdy, tag, vo);
    check($sformatf("v%0d_v_o", idx), vo, 32'(t.vo));
    if (t.chk) begin
      get_slot(int'(t.sel), int'(t.slot), d);
      check($sformatf("v%0d_slot%0d_data", idx, t.slot), d, 32'(t.sdata));
    end
  endtask

  initial begin
    logic [31:0] rdy, tag, vo;
    //                 sel v  data  yumi  rdy tag vo     chk slot data
    // els_p=2 skip: fill, full stall, drain+refill, drain
    vecs.push_back(mk(0, 1, 'h0A, 'b00,  1, 0, 'b01,  1, 0, 'h0A));
    vecs.push_back(mk(0, 1, 'h0B, 'b00,  1, 1, 'b11,  1, 1, 'h0B));
    vecs.push_back(mk(0, 1, 'h0D, 'b00,  0, 0, 'b11,  1, 0, 'h0A));
    vecs.push_back(mk(0, 1, 'h0C, 'b11,  1, 0, 'b01,  1, 0, 'h0C));
    vecs.push_back(mk(0, 0, 'h00, 'b01,  1, 1, 'b00,  0, 0, 'h00));
    // els_p=3 skip: reach slot1 full with ptr=1, then skip to slot2
    vecs.push_back(mk(1, 1, 'h11, 'b000, 1, 0, 'b001, 0, 0, 'h00));
    vecs.push_back(mk(1, 1, 'h12, 'b000, 1, 1, 'b011, 0, 0, 'h00));
    vecs.push_back(mk(1, 1, 'h13, 'b000, 1, 2, 'b111, 0, 0, 'h00));
    vecs.push_back(mk(1, 0, 'h00, 'b101, 1, 0, 'b010, 0, 0, 'h00));
    vecs.push_back(mk(1, 1, 'h14, 'b000, 1, 0, 'b011, 1, 0, 'h14));
    vecs.push_back(mk(1, 0, 'h00, 'b001, 1, 2, 'b010, 0, 0, 'h00));
    vecs.push_back(mk(1, 1, 'h15, 'b000, 1, 2, 'b110, 1, 2, 'h15));
    vecs.push_back(mk(1, 0, 'h00, 'b110, 1, 0, 'b000, 0, 0, 'h00));
    // els_p=3 strict: wrap 0,1,2,0,1,2 with immediate yumi
    vecs.push_back(mk(2, 1, 'h40, 'b000, 1, 0, 'b001, 1, 0, 'h40));
    vecs.push_back(mk(2, 1, 'h41, 'b001, 1, 1, 'b010, 1, 1, 'h41));
    vecs.push_back(mk(2, 1, 'h42, 'b010, 1, 2, 'b100, 1, 2, 'h42));
    vecs.push_back(mk(2, 1, 'h43, 'b100, 1, 0, 'b001, 0, 0, 'h00));
    vecs.push_back(mk(2, 1, 'h44, 'b001, 1, 1, 'b010, 0, 0, 'h00));
    vecs.push_back(mk(2, 1, 'h45, 'b010, 1, 2, 'b100, 0, 0, 'h00));
    vecs.push_back(mk(2, 0, 'h00, 'b100, 1, 0, 'b000, 0, 0, 'h00));
    // els_p=3 strict: slot1 full with ptr=1 stalls until its yumi
    vecs.push_back(mk(2, 1, 'h21, 'b000, 1, 0, 'b001, 1, 0, 'h21));
    vecs.push_back(mk(2, 1, 'h22, 'b000, 1, 1, 'b011, 0, 0, 'h00));
    vecs.push_back(mk(2, 1, 'h23, 'b000, 1, 2, 'b111, 1, 2, 'h23));
    vecs.push_back(mk(2, 0, 'h00, 'b101, 1, 0, 'b010, 0, 0, 'h00));
    vecs.push_back(mk(2, 1, 'h24, 'b000, 1, 0, 'b011, 1, 0, 'h24));
    vecs.push_back(mk(2, 0, 'h00, 'b001, 0, 1, 'b010, 0, 0, 'h00));
    vecs.push_back(mk(2, 1, 'h25, 'b000, 0, 1, 'b010, 1, 1, 'h22));
    vecs.push_back(mk(2, 1, 'h25, 'b010, 1, 1, 'b010, 1, 1, 'h25));
    // els_p=2: fill both again (ptr=1 first) ahead of the async reset
    vecs.push_back(mk(0, 1, 'h51, 'b00,  1, 1, 'b10,  1, 1, 'h51));
    vecs.push_back(mk(0, 1, 'h52, 'b00,  1, 0, 'b11,  1, 0, 'h52));

    rst_n = 1'b0;
    idle_all();
    repeat (2) @(negedge clk);
    #1;
    get_out(0, rdy, tag, vo); check("rst_d2_v_o", vo, 0); check("rst_d2_tag", tag, 0);
    get_out(1, rdy, tag, vo); check("rst_s3_v_o", vo, 0); check("rst_s3_tag", tag, 0);
    get_out(2, rdy, tag, vo); check("rst_t3_v_o", vo, 0); check("rst_t3_ready", rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // Reset dropped between edges must clear valids before the next edge.
    @(negedge clk);
    idle_all();
    #2;
    rst_n = 1'b0;
    #1;
    get_out(0, rdy, tag, vo); check("async_d2_v_o", vo, 0); check("async_d2_tag", tag, 0);
    get_out(2, rdy, tag, vo); check("async_t3_v_o", vo, 0); check("async_t3_tag", tag, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    apply(100, mk(0, 1, 'h53, 'b00, 1, 0, 'b01, 1, 0, 'h53));
    apply(101, mk(2, 1, 'h54, 'b000, 1, 0, 'b001, 1, 0, 'h54));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_round_robin_dispatch.md
Name: bsg_round_robin_dispatch

Overview:
- Single-producer, multi-consumer round-robin dispatcher: the distribution-side counterpart of the round-robin input arbiter.
- Accepts one valid/ready input stream and deals each accepted word to one of els_p output slots in rotating order.
- Each output slot holds one registered word until its consumer asserts yumi.
- Sits between a shared request source (e.g. a network or FIFO head) and replicated consumers such as banks or cores.

Parameters:
- els_p, 2, number of output consumers; must be at least 2; need not be a power of two.
- width_p, 32, data width in bits.
- strict_p, 0, ordering mode. 1 = strict rotation: wait for the pointed-to slot. 0 = skip occupied slots and take the first available slot in rotating order.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  input word valid.
- data_i  in  width_p  input word.
- ready_o  out  1  dispatcher can accept data_i this cycle. Combinational; does not depend on v_i.
- v_o  out  els_p  per-slot output valid (registered).
- data_o  out  els_p*width_p  per-slot output data. Slot k occupies bits [k*width_p +: width_p]. Registered.
- tag_o  out  max(1,clog2(els_p))  index of the slot that data_i would be written to this cycle. Combinational.
- yumi_i  in  els_p  per-slot consume. Legal only when the matching v_o bit is 1.

Behaviour:
- Reset (reset_n_i=0, asynchronous):
  - All v_o go to 0 immediately; the round-robin pointer ptr_r goes to 0; data_o contents are don't-care.
  - Assertion mid-operation discards all held words with no partial update.
  - Deassertion is synchronised externally; the first possible accept is on the first edge after release.
- Slot availability: avail[k] = ~v_o[k] | yumi_i[k]. A slot being drained this cycle can be refilled on the same edge.
- Target selection:
  - strict_p=1: tag_o = ptr_r; ready_o = avail[ptr_r].
  - strict_p=0: tag_o = first k with avail[k]=1, scanning ptr_r, ptr_r+1, … with wrap modulo els_p; ready_o = OR of avail. If no slot is available, tag_o = ptr_r.
- Accept: accept = v_i & ready_o. On an accept edge, slot tag_o loads data_i and v_o[tag_o] becomes 1. Latency is 1 cycle from accept to v_o.
- Pointer update: on accept, ptr_r becomes tag_o+1, wrapping from els_p-1 to 0 via explicit compare rather than bit truncation. Without an accept, ptr_r holds.
- Drain: yumi_i[k] clears v_o[k] on the next edge unless the same slot is refilled on that edge, in which case v_o[k] stays 1 and data_o carries the new word.
- Multiple yumi_i bits may be asserted in one cycle; each is handled independently.
- yumi_i[k] while v_o[k]=0 is a protocol error: simulation assertion, ignored in hardware.
- v_i=1 with ready_o=0: nothing changes; the producer must hold data_i stable.
- At most one word is accepted per cycle, so throughput is ≤1 word/cycle.
- No combinational path from v_i to ready_o. yumi_i does feed ready_o and tag_o combinationally.

Decomposition:
- Shared package bsg_dispatch_pkg:
  - function for pointer width, max(1,clog2(els_p));
  - wrap-increment function;
  - strict/skip mode enum constants.
- One sub-module, bsg_rr_dispatch_scan: combinational rotating find-first-set. Inputs are the avail vector and ptr_r; outputs are the found index and an any-found flag. Strict mode bypasses it.
- Top level holds ptr_r, the els_p slot registers and the valid bits.

Test Plan:
- Reset and fill, els_p=2, strict_p=0: reset, then v_i=1 for data 0xA, then 0xB, with no yumi → slot0=0xA, slot1=0xB, v_o=2'b11, ready_o=0 after the second edge; tag_o sequence is 0, 1.
- Skip, strict_p=0, els_p=3: slot1 held full and ptr_r=1 → tag_o=2; after accept, ptr_r=0.
- Strict stall, strict_p=1, els_p=3: same state as the skip test → ready_o=0 until yumi_i[1]=1. In that cycle ready_o=1 and tag_o=1; the new word loads slot1 and v_o[1] stays 1.
- Wrap with non-power-of-two count, els_p=3, strict_p=1: 6 accepts with an immediate yumi each → tag_o = 0,1,2,0,1,2.
- Simultaneous drain and refill, all slots full, els_p=2: yumi_i=2'b11 with v_i=1 and data 0xC → slot ptr_r gets 0xC and stays valid; the other slot's v_o clears.
- Asynchronous reset mid-stream: drop reset_n_i between clock edges with v_o=2'b11 → v_o=0 before the next edge; after release, the first accept goes to slot 0.
